// File: rtl/cache_pkg.sv
// Shared types for the two-way cache controller: FSM state encoding and way index.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  typedef logic way_t;

endpackage

// File: rtl/cache_control.sv
// Two-way set-associative cache controller: zero-wait hits in IDLE, with
// WRITEBACK of a dirty victim and ALLOCATE of the missing line on a miss.
module cache_control
  import cache_pkg::*;
#(
  parameter int s_index = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic [1:0] hit,
  input  logic [1:0] dirty,
  input  logic       lru,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  output logic [1:0] load_data,
  output logic [1:0] load_tag,
  output logic [1:0] load_valid,
  output logic [1:0] load_dirty,
  output logic       dirty_in,
  output logic       load_lru,
  output logic       lru_in,
  output logic       data_sel,
  output logic       pmem_addr_sel
);

  if (s_index < 1) begin : g_bad_s_index
    $error("cache_control: s_index must be at least 1");
  end

  state_e state_q, state_d;
  way_t   victim_q, victim_d;
  way_t   hit_way;
  logic   req;

  assign req     = mem_read | mem_write;
  assign hit_way = ~hit[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Outputs are additionally gated by rst_n so every strobe drops the moment reset asserts.
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_data     = 2'b00;
    load_tag      = 2'b00;
    load_valid    = 2'b00;
    load_dirty    = 2'b00;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;

    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (|hit) begin
              mem_resp = 1'b1;
              load_lru = 1'b1;
              lru_in   = ~hit_way;
              if (mem_write) begin
                load_data[hit_way]  = 1'b1;
                load_dirty[hit_way] = 1'b1;
                dirty_in            = 1'b1;
                data_sel            = 1'b0;
              end
            end else begin
              victim_d = lru;
              state_d  = dirty[lru] ? WRITEBACK : ALLOCATE;
            end
          end
        end

        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          if (pmem_resp) begin
            load_dirty[victim_q] = 1'b1;
            dirty_in             = 1'b0;
            state_d              = ALLOCATE;
          end
        end

        ALLOCATE: begin
          pmem_read     = 1'b1;
          pmem_addr_sel = 1'b0;
          if (pmem_resp) begin
            load_data[victim_q]  = 1'b1;
            load_tag[victim_q]   = 1'b1;
            load_valid[victim_q] = 1'b1;
            load_dirty[victim_q] = 1'b1;
            data_sel             = 1'b1;
            dirty_in             = 1'b0;
            state_d              = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed-vector bench for cache_control; every expected output word is hand-computed.
module tb_cache_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write, pmem_resp, lru;
  logic [1:0] hit, dirty;
  logic       mem_resp, pmem_read, pmem_write, dirty_in, load_lru, lru_in, data_sel, pmem_addr_sel;
  logic [1:0] load_data, load_tag, load_valid, load_dirty;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_o;
  wire  [15:0] outs = {mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid,
                       load_dirty, dirty_in, load_lru, lru_in, data_sel, pmem_addr_sel};

  always #5 clk = ~clk;

  cache_control #(.s_index(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .dirty(dirty), .lru(lru), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in),
    .data_sel(data_sel), .pmem_addr_sel(pmem_addr_sel)
  );

  // Packs an expected output word in the same field order as 'outs'.
  function automatic logic [15:0] o(input logic resp, input logic prd, input logic pwr,
                                    input logic [1:0] ld, input logic [1:0] lt,
                                    input logic [1:0] lv, input logic [1:0] ldy,
                                    input logic din, input logic llru, input logic lin,
                                    input logic dsel, input logic asel);
    return {resp, prd, pwr, ld, lt, lv, ldy, din, llru, lin, dsel, asel};
  endfunction

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; pmem_resp = 0; hit = 2'b00; dirty = 2'b00; lru = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs(); rst_n = 0;
    #2;
    exp_o = '0; vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL reset_idle: got %b expected %b", outs, exp_o); end
    mem_write = 1; hit = 2'b01;
    #2;
    vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL reset_req_hit: got %b expected %b", outs, exp_o); end
    idle_inputs();
    next_cycle(); rst_n = 1;
    next_cycle();
  endtask

  task automatic test_write_hit();
    mem_write = 1; hit = 2'b01; sample();
    exp_o = o(1,0,0, 2'b01,2'b00,2'b00,2'b01, 1,1,1,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wr_hit_w0: got %b expected %b", outs, exp_o); end
    next_cycle(); hit = 2'b10; sample();
    exp_o = o(1,0,0, 2'b10,2'b00,2'b00,2'b10, 1,1,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wr_hit_w1: got %b expected %b", outs, exp_o); end
    next_cycle(); hit = 2'b11; sample();
    exp_o = o(1,0,0, 2'b01,2'b00,2'b00,2'b01, 1,1,1,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wr_hit_both: got %b expected %b", outs, exp_o); end
    next_cycle(); mem_read = 1; hit = 2'b10; sample();
    exp_o = o(1,0,0, 2'b10,2'b00,2'b00,2'b10, 1,1,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rdwr_hit_w1: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_read_hit();
    mem_read = 1; hit = 2'b10; sample();
    exp_o = o(1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rd_hit_w1: got %b expected %b", outs, exp_o); end
    next_cycle(); hit = 2'b11; pmem_resp = 1; sample();
    exp_o = o(1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,1,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rd_hit_both_pmemresp: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs(); pmem_resp = 1; hit = 2'b01; sample();
    exp_o = '0; vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL idle_pmem_resp: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_clean_miss();
    mem_read = 1; hit = 2'b00; dirty = 2'b00; lru = 1; sample();
    exp_o = '0; vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL clean_miss_c0: got %b expected %b", outs, exp_o); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); sample();
      exp_o = o(0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0); vectors++;
      if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL clean_alloc_c%0d: got %b expected %b", c, outs, exp_o); end
    end
    next_cycle(); pmem_resp = 1; sample();
    exp_o = o(0,1,0, 2'b10,2'b10,2'b10,2'b10, 0,0,0,1,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL clean_fill: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 0; hit = 2'b10; sample();
    exp_o = o(1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL clean_replay_hit: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_dirty_lru_select();
    // dirty[0] is set but lru picks way 1, which is clean, so no writeback.
    mem_read = 1; hit = 2'b00; dirty = 2'b01; lru = 1;
    next_cycle(); sample();
    exp_o = o(0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL dirty_sel_alloc: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 1; sample();
    exp_o = o(0,1,0, 2'b10,2'b10,2'b10,2'b10, 0,0,0,1,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL dirty_sel_fill: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_dirty_miss();
    mem_write = 1; hit = 2'b00; lru = 0; dirty = 2'b01; sample();
    exp_o = '0; vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL dirty_miss_c0: got %b expected %b", outs, exp_o); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); sample();
      exp_o = o(0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,1); vectors++;
      if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wb_c%0d: got %b expected %b", c, outs, exp_o); end
    end
    next_cycle(); pmem_resp = 1; sample();
    exp_o = o(0,0,1, 2'b00,2'b00,2'b00,2'b01, 0,0,0,0,1); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wb_done: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 0; lru = 1; sample();
    exp_o = o(0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wb_then_alloc: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 1; sample();
    exp_o = o(0,1,0, 2'b01,2'b01,2'b01,2'b01, 0,0,0,1,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL fill_latched_victim: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 0; hit = 2'b01; dirty = 2'b00; sample();
    exp_o = o(1,0,0, 2'b01,2'b00,2'b00,2'b01, 1,1,1,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL dirty_replay_hit: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_victim_way1_writeback();
    mem_read = 1; hit = 2'b00; lru = 1; dirty = 2'b10;
    next_cycle(); lru = 0; pmem_resp = 1; sample();
    exp_o = o(0,0,1, 2'b00,2'b00,2'b00,2'b10, 0,0,0,0,1); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL wb_victim1: got %b expected %b", outs, exp_o); end
    next_cycle(); sample();
    exp_o = o(0,1,0, 2'b10,2'b10,2'b10,2'b10, 0,0,0,1,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL fill_victim1: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_reset_mid_writeback();
    mem_write = 1; hit = 2'b00; lru = 0; dirty = 2'b01;
    next_cycle(); sample();
    exp_o = o(0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,1); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rst_wb_entry: got %b expected %b", outs, exp_o); end
    #1 rst_n = 0;
    #1;
    exp_o = '0; vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rst_wb_async: got %b expected %b", outs, exp_o); end
    idle_inputs();
    next_cycle(); rst_n = 1; pmem_resp = 1; sample();
    vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rst_wb_after: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 0; mem_read = 1; hit = 2'b01; sample();
    exp_o = o(1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,1,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL rst_wb_idle_hit: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_drop_mid_allocate();
    mem_read = 1; hit = 2'b00; lru = 0; dirty = 2'b00;
    next_cycle(); mem_read = 0; sample();
    exp_o = o(0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0,0,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL drop_alloc: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 1; sample();
    exp_o = o(0,1,0, 2'b01,2'b01,2'b01,2'b01, 0,0,0,1,0); vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL drop_fill: got %b expected %b", outs, exp_o); end
    next_cycle(); pmem_resp = 0; hit = 2'b01; sample();
    exp_o = '0; vectors++;
    if (outs !== exp_o) begin miscompares++; $display("[TB] FAIL drop_no_resp: got %b expected %b", outs, exp_o); end
    next_cycle(); idle_inputs();
  endtask

  initial begin
    idle_inputs(); rst_n = 0;
    next_cycle();
    test_reset();
    test_write_hit();
    test_read_hit();
    test_clean_miss();
    test_dirty_lru_select();
    test_dirty_miss();
    test_victim_way1_writeback();
    test_reset_mid_writeback();
    test_drop_mid_allocate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
